// File: rtl/sigma_keyed_stage.sv
// AES key-addition stage: out = in ^ bank[idx], with a local round-key bank,
// valid/ready handshake, a single output register, bypass and index-range error flag.
module sigma_keyed_stage #(
  parameter int unsigned DATA_W   = 128,
  parameter int unsigned NUM_KEYS = 15,
  parameter int unsigned IDX_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_wr_en,
  input  logic [IDX_W-1:0]  key_wr_idx,
  input  logic [DATA_W-1:0] key_wr_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [IDX_W-1:0]  in_key_idx,
  input  logic              in_bypass,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_key_err
);

  if ((DATA_W % 8) != 0 || DATA_W < 8) begin : g_bad_data_w
    $error("DATA_W must be a non-zero multiple of 8");
  end
  if ((64'd1 << IDX_W) < 64'(NUM_KEYS)) begin : g_bad_idx_w
    $error("IDX_W too narrow to address NUM_KEYS entries");
  end

  // One extra bit so the range compare never wraps when NUM_KEYS == 2**IDX_W.
  localparam logic [IDX_W:0] NumKeys = (IDX_W + 1)'(NUM_KEYS);

  logic [DATA_W-1:0] bank_q [NUM_KEYS];
  logic [DATA_W-1:0] bank_d [NUM_KEYS];

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic              out_key_err_q, out_key_err_d;

  logic              wr_hit;
  logic              idx_in_range;
  logic              idx_err;
  logic              accept;
  logic [DATA_W-1:0] key_sel;

  assign wr_hit       = key_wr_en && ({1'b0, key_wr_idx} < NumKeys);
  assign idx_in_range = {1'b0, in_key_idx} < NumKeys;
  assign idx_err      = !idx_in_range && !in_bypass;
  assign in_ready     = !out_valid_q || out_ready;
  assign accept       = in_valid && in_ready;

  always_comb begin
    bank_d = bank_q;
    if (wr_hit) begin
      for (int k = 0; k < int'(NUM_KEYS); k++) begin
        if (key_wr_idx == IDX_W'(k)) begin
          bank_d[k] = key_wr_data;
        end
      end
    end
  end

  // Reading the post-write bank gives same-cycle write-through to the datapath.
  always_comb begin
    key_sel = '0;
    if (!in_bypass && idx_in_range) begin
      for (int k = 0; k < int'(NUM_KEYS); k++) begin
        if (in_key_idx == IDX_W'(k)) begin
          key_sel = bank_d[k];
        end
      end
    end
  end

  always_comb begin
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_key_err_d = out_key_err_q;
    if (accept) begin
      out_valid_d   = 1'b1;
      out_data_d    = in_data ^ key_sel;
      out_key_err_d = idx_err;
    end else if (out_ready) begin
      out_valid_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_key_err_q <= 1'b0;
      for (int k = 0; k < int'(NUM_KEYS); k++) begin
        bank_q[k] <= '0;
      end
    end else begin
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_key_err_q <= out_key_err_d;
      for (int k = 0; k < int'(NUM_KEYS); k++) begin
        bank_q[k] <= bank_d[k];
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_key_err = out_key_err_q;

endmodule

// File: tb/tb_sigma_keyed_stage.sv
// Bench for sigma_keyed_stage: directed scenarios plus a randomized run against
// a queue-based model of the key bank and output stream.
module tb_sigma_keyed_stage;

  localparam int DW = 128;
  localparam int NK = 15;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          key_wr_en;
  logic [IW-1:0] key_wr_idx;
  logic [DW-1:0] key_wr_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [IW-1:0] in_key_idx;
  logic          in_bypass;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_key_err;

  sigma_keyed_stage #(.DATA_W(DW), .NUM_KEYS(NK), .IDX_W(IW)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_wr_en  (key_wr_en),
    .key_wr_idx (key_wr_idx),
    .key_wr_data(key_wr_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_key_idx (in_key_idx),
    .in_bypass  (in_bypass),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_key_err(out_key_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [DW-1:0] mdl_bank [NK];
  exp_t          exp_q [$];

  function automatic logic [DW-1:0] rnd_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [DW-1:0] model_key(input logic [IW-1:0] idx, input logic byp);
    if (byp || int'(idx) >= NK) return '0;
    return mdl_bank[int'(idx)];
  endfunction

  // Advances one clock: applies this cycle's inputs to the model, then returns at the next negedge.
  task automatic tick();
    exp_t e;
    #1;
    if (rst) begin
      exp_q.delete();
      for (int k = 0; k < NK; k++) mdl_bank[k] = '0;
    end else begin
      if (out_valid && out_ready && exp_q.size() > 0) exp_q.delete(0);
      if (key_wr_en && int'(key_wr_idx) < NK) mdl_bank[int'(key_wr_idx)] = key_wr_data;
      if (in_valid && in_ready) begin
        e.err  = (int'(in_key_idx) >= NK) && !in_bypass;
        e.data = in_data ^ model_key(in_key_idx, in_bypass);
        exp_q.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    key_wr_en = 1'b0; key_wr_idx = '0; key_wr_data = '0;
    in_valid = 1'b0; in_data = '0; in_key_idx = '0; in_bypass = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic write_key(input logic [IW-1:0] idx, input logic [DW-1:0] k);
    key_wr_en = 1'b1; key_wr_idx = idx; key_wr_data = k;
    tick();
    key_wr_en = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    n_checks += 4;
    if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    if (out_data !== '0) begin n_errors++; $display("FAIL reset_data got=%h want=0", out_data); end
    if (out_key_err !== 1'b0) begin n_errors++; $display("FAIL reset_err got=%b want=0", out_key_err); end
    if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_fips();
    write_key(4'd0, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    in_valid = 1'b1; in_data = 128'h3243f6a8885a308d313198a2e0370734; in_key_idx = 4'd0;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks += 3;
    if (out_valid !== 1'b1) begin n_errors++; $display("FAIL fips_valid got=%b want=1", out_valid); end
    if (out_data !== 128'h193de3bea0f4e22b9ac68d2ae9f84808) begin
      n_errors++; $display("FAIL fips_data got=%h want=193de3bea0f4e22b9ac68d2ae9f84808", out_data);
    end
    if (out_key_err !== 1'b0) begin n_errors++; $display("FAIL fips_err got=%b want=0", out_key_err); end
    tick();
  endtask

  task automatic test_throughput();
    for (int k = 0; k < NK; k++) write_key(IW'(k), rnd_blk());
    for (int i = 0; i < NK; i++) begin
      in_valid = 1'b1; in_data = rnd_blk(); in_key_idx = IW'(i); in_bypass = 1'b0;
      out_ready = 1'b1;
      #1;
      if (i > 0) begin
        n_checks += 2;
        if (out_valid !== 1'b1) begin n_errors++; $display("FAIL tput_valid[%0d] got=%b want=1", i, out_valid); end
        if (exp_q.size() == 0 || out_data !== exp_q[0].data) begin
          n_errors++; $display("FAIL tput_data[%0d] got=%h", i, out_data);
        end
      end
      tick();
    end
    in_valid = 1'b0;
    n_checks += 2;
    if (out_valid !== 1'b1) begin n_errors++; $display("FAIL tput_last_valid got=%b want=1", out_valid); end
    if (exp_q.size() != 1 || out_data !== exp_q[0].data) begin
      n_errors++; $display("FAIL tput_last_data got=%h queued=%0d", out_data, exp_q.size());
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] blk [4];
    int j = 0;
    int got = 0;
    logic stalled;
    for (int i = 0; i < 4; i++) blk[i] = rnd_blk();
    for (int cyc = 0; cyc < 12; cyc++) begin
      stalled   = (cyc >= 2 && cyc <= 4);
      out_ready = !stalled;
      in_valid  = (j < 4);
      in_data   = blk[j % 4];
      in_key_idx = IW'(j % 4);
      in_bypass = 1'b0;
      #1;
      if (out_valid) begin
        n_checks++;
        if (exp_q.size() == 0 || out_data !== exp_q[0].data) begin
          n_errors++; $display("FAIL bp_data[cyc%0d] got=%h", cyc, out_data);
        end
        if (stalled) begin
          n_checks++;
          if (in_ready !== 1'b0) begin n_errors++; $display("FAIL bp_ready[cyc%0d] got=%b want=0", cyc, in_ready); end
        end
        if (out_ready) got++;
      end
      if (in_valid && in_ready) j++;
      tick();
    end
    in_valid = 1'b0;
    n_checks += 2;
    if (got != 4) begin n_errors++; $display("FAIL bp_count got=%0d want=4", got); end
    if (exp_q.size() != 0) begin n_errors++; $display("FAIL bp_leftover got=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_forwarding();
    logic [DW-1:0] k_new, d, k_late;
    k_new = rnd_blk(); d = rnd_blk(); k_late = rnd_blk();
    write_key(4'd5, rnd_blk());
    key_wr_en = 1'b1; key_wr_idx = 4'd5; key_wr_data = k_new;
    in_valid = 1'b1; in_data = d; in_key_idx = 4'd5; in_bypass = 1'b0; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    // Overwrite the slot while the block is held; the output must not change.
    key_wr_en = 1'b1; key_wr_data = k_late; out_ready = 1'b0;
    n_checks++;
    if (out_data !== (d ^ k_new)) begin n_errors++; $display("FAIL fwd_data got=%h want=%h", out_data, d ^ k_new); end
    tick();
    key_wr_en = 1'b0;
    n_checks++;
    if (out_data !== (d ^ k_new)) begin n_errors++; $display("FAIL fwd_hold got=%h want=%h", out_data, d ^ k_new); end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b1; in_data = d; in_key_idx = 4'd5;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_data !== (d ^ k_late)) begin n_errors++; $display("FAIL fwd_late got=%h want=%h", out_data, d ^ k_late); end
    tick();
  endtask

  task automatic test_err_bypass();
    logic [DW-1:0] d;
    logic [IW-1:0] idx_t [3] = '{4'd15, 4'd15, 4'd3};
    logic          byp_t [3] = '{1'b0, 1'b1, 1'b1};
    logic          err_t [3] = '{1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      d = rnd_blk();
      in_valid = 1'b1; in_data = d; in_key_idx = idx_t[i]; in_bypass = byp_t[i]; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      n_checks += 2;
      if (out_data !== d) begin n_errors++; $display("FAIL eb_data[%0d] got=%h want=%h", i, out_data, d); end
      if (out_key_err !== err_t[i]) begin
        n_errors++; $display("FAIL eb_err[%0d] got=%b want=%b", i, out_key_err, err_t[i]);
      end
    end
    in_bypass = 1'b0;
    tick();
  endtask

  task automatic test_reset_midstream();
    logic [DW-1:0] d;
    write_key(4'd0, rnd_blk());
    in_valid = 1'b1; in_data = rnd_blk(); in_key_idx = 4'd0; out_ready = 1'b0;
    tick();
    rst = 1'b1; in_data = rnd_blk();
    key_wr_en = 1'b1; key_wr_idx = 4'd0; key_wr_data = rnd_blk();
    tick();
    rst = 1'b0; in_valid = 1'b0; key_wr_en = 1'b0;
    n_checks += 3;
    if (out_valid !== 1'b0) begin n_errors++; $display("FAIL rstm_valid got=%b want=0", out_valid); end
    if (out_data !== '0) begin n_errors++; $display("FAIL rstm_data got=%h want=0", out_data); end
    if (in_ready !== 1'b1) begin n_errors++; $display("FAIL rstm_ready got=%b want=1", in_ready); end
    d = rnd_blk();
    in_valid = 1'b1; in_data = d; in_key_idx = 4'd0; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_data !== d) begin n_errors++; $display("FAIL rstm_bank got=%h want=%h", out_data, d); end
    tick();
  endtask

  task automatic test_random();
    logic holding = 1'b0;
    logic acc;
    for (int cyc = 0; cyc < 400; cyc++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      key_wr_en = ($urandom_range(0, 3) == 0);
      key_wr_idx = IW'($urandom_range(0, 15));
      key_wr_data = rnd_blk();
      if (!holding) begin
        in_valid = ($urandom_range(0, 4) != 0);
        in_data = rnd_blk();
        in_key_idx = IW'($urandom_range(0, 15));
        in_bypass = ($urandom_range(0, 7) == 0);
      end
      #1;
      acc = in_valid && in_ready;
      n_checks += 2;
      if (in_ready !== (!out_valid || out_ready)) begin
        n_errors++; $display("FAIL rnd_ready[%0d] got=%b", cyc, in_ready);
      end
      if (int'(out_valid) != exp_q.size()) begin
        n_errors++; $display("FAIL rnd_occupancy[%0d] got=%b want=%0d", cyc, out_valid, exp_q.size());
      end
      if (out_valid && exp_q.size() > 0) begin
        n_checks += 2;
        if (out_data !== exp_q[0].data) begin
          n_errors++; $display("FAIL rnd_data[%0d] got=%h want=%h", cyc, out_data, exp_q[0].data);
        end
        if (out_key_err !== exp_q[0].err) begin
          n_errors++; $display("FAIL rnd_err[%0d] got=%b want=%b", cyc, out_key_err, exp_q[0].err);
        end
      end
      tick();
      holding = in_valid && !acc;
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    for (int k = 0; k < NK; k++) mdl_bank[k] = '0;
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_fips();
    test_throughput();
    test_back_to_back();
    test_forwarding();
    test_err_bypass();
    test_reset_midstream();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
